// File: rtl/data_mem_pkg.sv
// Shared definitions for the BIP data memory and its arbiter.
//   op_e    : two-bit request encoding used by both requesters
//   ARB_*   : arbitration policy selectors
//   state_e : sweep / run controller states
package data_mem_pkg;

  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_READ    = 2'b01,
    OP_WRITE   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  // Any non-idle op occupies the port, including the illegal code.
  function automatic logic is_request(input op_e op);
    return op != OP_IDLE;
  endfunction

endpackage

// File: rtl/data_mem_arbiter.sv
// Two-requester grant logic for the data memory port.
//   clk, rst_n : clock, synchronous active-low reset
//   enable     : grants are only issued while the memory is in service
//   bip_req    : BIP datapath requests the port
//   if_req     : host/debug interface requests the port
//   bip_grant  : BIP owns the port this cycle (combinational)
//   if_grant   : interface owns the port this cycle (combinational)
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic bip_req,
  input  logic if_req,
  output logic bip_grant,
  output logic if_grant
);

  // Winner of the most recent conflict; starts at interface so BIP wins first.
  logic last_if;

  always_comb begin
    bip_grant = 1'b0;
    if_grant  = 1'b0;
    if (enable) begin
      if (bip_req && if_req) begin
        if (ARB_MODE == ARB_RR && !last_if) begin
          if_grant = 1'b1;
        end else begin
          bip_grant = 1'b1;
        end
      end else begin
        bip_grant = bip_req;
        if_grant  = if_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_if <= 1'b1;
    end else if (enable && bip_req && if_req) begin
      last_if <= if_grant;
    end
  end

endmodule

// File: rtl/data_memory_arb.sv
// Single-port BIP data RAM shared by the BIP datapath and the host interface.
//   clk, rst_n                       : clock, synchronous active-low reset
//   WrRdBip / addr_from_bip / data_from_bip : BIP op, address, write data
//   bip_rdata, bip_rvalid, bip_stall : BIP read data, read-done pulse, hold request
//   WrRdInterface / addr_from_interface / data_from_interface : interface request
//   if_rdata, if_rvalid, if_stall    : interface read data, read-done pulse, hold
//   mem_ready                        : clear sweep finished, port in service
//   err_sticky, err_clr              : illegal op / out-of-range address flag, clear
module data_memory_arb
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_LENGTH    = 11,
  parameter int unsigned DATA_LENGTH    = 16,
  parameter int unsigned DEPTH          = 2048,
  parameter int unsigned ARB_MODE       = ARB_FIXED,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter string       INIT_FILE      = ""
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             WrRdBip,
  input  logic [ADDR_LENGTH-1:0] addr_from_bip,
  input  logic [DATA_LENGTH-1:0] data_from_bip,
  output logic [DATA_LENGTH-1:0] bip_rdata,
  output logic                   bip_rvalid,
  output logic                   bip_stall,
  input  logic [1:0]             WrRdInterface,
  input  logic [ADDR_LENGTH-1:0] addr_from_interface,
  input  logic [DATA_LENGTH-1:0] data_from_interface,
  output logic [DATA_LENGTH-1:0] if_rdata,
  output logic                   if_rvalid,
  output logic                   if_stall,
  output logic                   mem_ready,
  output logic                   err_sticky,
  input  logic                   err_clr
);

  localparam int unsigned       CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_ADDR = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_LENGTH:0] DEPTH_W = (ADDR_LENGTH + 1)'(DEPTH);

  state_e                   state;
  logic [CNT_W-1:0]         clr_cnt;
  logic [DATA_LENGTH-1:0]   mem [DEPTH];

  op_e                      bip_op, if_op;
  logic                     bip_req, if_req, bip_grant, if_grant, run;
  op_e                      acc_op;
  logic [ADDR_LENGTH-1:0]   acc_addr;
  logic [DATA_LENGTH-1:0]   acc_data;
  logic                     acc_err, acc_rd;
  logic                     mem_we;
  logic [CNT_W-1:0]         mem_addr;
  logic [DATA_LENGTH-1:0]   mem_wdata;

  assign bip_op  = op_e'(WrRdBip);
  assign if_op   = op_e'(WrRdInterface);
  assign bip_req = is_request(bip_op);
  assign if_req  = is_request(if_op);
  assign run     = (state == ST_RUN);

  data_mem_arbiter #(
    .ARB_MODE (ARB_MODE)
  ) u_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (run),
    .bip_req   (bip_req),
    .if_req    (if_req),
    .bip_grant (bip_grant),
    .if_grant  (if_grant)
  );

  assign bip_stall = !run || (bip_req && !bip_grant);
  assign if_stall  = !run || (if_req && !if_grant);

  always_comb begin
    acc_op   = OP_IDLE;
    acc_addr = '0;
    acc_data = '0;
    if (bip_grant) begin
      acc_op   = bip_op;
      acc_addr = addr_from_bip;
      acc_data = data_from_bip;
    end else if (if_grant) begin
      acc_op   = if_op;
      acc_addr = addr_from_interface;
      acc_data = data_from_interface;
    end
    acc_err = (acc_op == OP_ILLEGAL) ||
              ((acc_op != OP_IDLE) && ({1'b0, acc_addr} >= DEPTH_W));
    acc_rd  = (acc_op == OP_READ) || (acc_op == OP_ILLEGAL);
  end

  // The sweep and the granted access share the one RAM port.
  always_comb begin
    if (!run) begin
      mem_we    = (CLEAR_ON_RESET != 0);
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end else begin
      mem_we    = (acc_op == OP_WRITE) && !acc_err;
      mem_addr  = acc_addr[CNT_W-1:0];
      mem_wdata = acc_data;
    end
  end

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      mem_ready  <= 1'b0;
      bip_rdata  <= '0;
      bip_rvalid <= 1'b0;
      if_rdata   <= '0;
      if_rvalid  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      bip_rvalid <= 1'b0;
      if_rvalid  <= 1'b0;
      mem_ready  <= run;
      case (state)
        ST_CLEAR: begin
          if (CLEAR_ON_RESET == 0 || clr_cnt == LAST_ADDR) begin
            state <= ST_RUN;
          end else begin
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (bip_grant && acc_rd) begin
            bip_rvalid <= 1'b1;
            bip_rdata  <= acc_err ? '0 : mem[mem_addr];
          end
          if (if_grant && acc_rd) begin
            if_rvalid <= 1'b1;
            if_rdata  <= acc_err ? '0 : mem[mem_addr];
          end
        end
        default: state <= ST_CLEAR;
      endcase
      if (acc_err) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_arb.sv
module tb_data_memory_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_bip, wr_if;
  logic [4:0]  a_bip, a_if;
  logic [15:0] d_bip, d_if;
  logic        clr;

  logic [15:0] b_rdata [3];
  logic [15:0] i_rdata [3];
  logic        b_rv [3], i_rv [3], b_st [3], i_st [3], rdy [3], err [3];

  int checks = 0;
  int passes = 0;

  // Reference state for dut 0 (fixed priority) and dut 1 (round robin).
  logic [15:0] mem_m [2][16];
  bit          last_if [2];
  logic [15:0] brd_m [2], ird_m [2];
  bit          err_m [2];

  always #5 clk = ~clk;

  data_memory_arb #(.ADDR_LENGTH(5), .DATA_LENGTH(16), .DEPTH(16), .ARB_MODE(0),
                    .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .WrRdBip(wr_bip), .addr_from_bip(a_bip), .data_from_bip(d_bip),
    .bip_rdata(b_rdata[0]), .bip_rvalid(b_rv[0]), .bip_stall(b_st[0]),
    .WrRdInterface(wr_if), .addr_from_interface(a_if), .data_from_interface(d_if),
    .if_rdata(i_rdata[0]), .if_rvalid(i_rv[0]), .if_stall(i_st[0]),
    .mem_ready(rdy[0]), .err_sticky(err[0]), .err_clr(clr));

  data_memory_arb #(.ADDR_LENGTH(5), .DATA_LENGTH(16), .DEPTH(16), .ARB_MODE(1),
                    .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .WrRdBip(wr_bip), .addr_from_bip(a_bip), .data_from_bip(d_bip),
    .bip_rdata(b_rdata[1]), .bip_rvalid(b_rv[1]), .bip_stall(b_st[1]),
    .WrRdInterface(wr_if), .addr_from_interface(a_if), .data_from_interface(d_if),
    .if_rdata(i_rdata[1]), .if_rvalid(i_rv[1]), .if_stall(i_st[1]),
    .mem_ready(rdy[1]), .err_sticky(err[1]), .err_clr(clr));

  data_memory_arb #(.ADDR_LENGTH(5), .DATA_LENGTH(16), .DEPTH(16), .ARB_MODE(0),
                    .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .WrRdBip(wr_bip), .addr_from_bip(a_bip), .data_from_bip(d_bip),
    .bip_rdata(b_rdata[2]), .bip_rvalid(b_rv[2]), .bip_stall(b_st[2]),
    .WrRdInterface(wr_if), .addr_from_interface(a_if), .data_from_interface(d_if),
    .if_rdata(i_rdata[2]), .if_rvalid(i_rv[2]), .if_stall(i_st[2]),
    .mem_ready(rdy[2]), .err_sticky(err[2]), .err_clr(clr));

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
  endtask

  task automatic drive(input logic [1:0] bop, input logic [4:0] ba, input logic [15:0] bd,
                       input logic [1:0] iop, input logic [4:0] ia, input logic [15:0] id,
                       input logic c);
    wr_bip = bop; a_bip = ba; d_bip = bd;
    wr_if  = iop; a_if  = ia; d_if  = id;
    clr    = c;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) mem_m[d][a] = 16'h0;
      last_if[d] = 1'b1;
      brd_m[d] = 16'h0;
      ird_m[d] = 16'h0;
      err_m[d] = 1'b0;
    end
  endtask

  task automatic access(input int d, input logic [1:0] op, input logic [4:0] a,
                        input logic [15:0] wd, inout logic [15:0] rd,
                        output bit rv, output bit e);
    e  = (op == 2'b11) || (a >= 5'd16);
    rv = (op == 2'b01) || (op == 2'b11);
    if (op == 2'b10 && !e) mem_m[d][a[3:0]] = wd;
    if (rv) rd = e ? 16'h0 : mem_m[d][a[3:0]];
  endtask

  // One clock of traffic: stall checked before the edge, results after it.
  task automatic step(input logic [1:0] bop, input logic [4:0] ba, input logic [15:0] bd,
                      input logic [1:0] iop, input logic [4:0] ia, input logic [15:0] id,
                      input logic c);
    bit bg [2];
    bit ig [2];
    bit breq, ireq, brv, irv, eb, ei;
    drive(bop, ba, bd, iop, ia, id, c);
    #2;
    breq = (bop != 2'b00);
    ireq = (iop != 2'b00);
    for (int d = 0; d < 2; d++) begin
      bg[d] = breq && (!ireq || d == 0 || last_if[d]);
      ig[d] = ireq && !bg[d];
      chk("bip_stall", d, b_st[d], breq && !bg[d]);
      chk("if_stall", d, i_st[d], ireq && !ig[d]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      brv = 0; irv = 0; eb = 0; ei = 0;
      if (breq && ireq && d == 1) last_if[1] = ig[1];
      if (bg[d]) access(d, bop, ba, bd, brd_m[d], brv, eb);
      if (ig[d]) access(d, iop, ia, id, ird_m[d], irv, ei);
      err_m[d] = (eb || ei) ? 1'b1 : (c ? 1'b0 : err_m[d]);
      chk("bip_rvalid", d, b_rv[d], brv);
      chk("bip_rdata", d, b_rdata[d], brd_m[d]);
      chk("if_rvalid", d, i_rv[d], irv);
      chk("if_rdata", d, i_rdata[d], ird_m[d]);
      chk("err_sticky", d, err[d], err_m[d]);
      chk("mem_ready", d, rdy[d], 1'b1);
    end
  endtask

  // Reset, then count edges until each dut reports ready; abort_after>0 stops mid-sweep.
  task automatic reset_and_wait(input int abort_after);
    int rdy_n [3];
    drive(2'b00, 5'd0, 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      chk("rst_bip_rdata", d, b_rdata[d], 16'h0);
      chk("rst_if_rdata", d, i_rdata[d], 16'h0);
      chk("rst_rvalid", d, {b_rv[d], i_rv[d]}, 2'b00);
      chk("rst_err", d, err[d], 1'b0);
      chk("rst_ready", d, rdy[d], 1'b0);
      chk("rst_stalls", d, {b_st[d], i_st[d]}, 2'b11);
    end
    rst_n = 1'b1;
    rdy_n = '{0, 0, 0};
    for (int n = 1; n <= 40; n++) begin
      if (n <= 10) drive(2'b10, 5'd3, 16'h5555, 2'b01, 5'd3, 16'h0, 1'b0);
      else         drive(2'b00, 5'd0, 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);
      @(posedge clk);
      #1;
      if (abort_after != 0 && n == abort_after) return;
      for (int d = 0; d < 3; d++) if (rdy[d] && rdy_n[d] == 0) rdy_n[d] = n;
      if (n <= 15) begin
        for (int d = 0; d < 2; d++) begin
          chk("clear_stalls", d, {b_st[d], i_st[d]}, 2'b11);
          chk("clear_rvalid", d, {b_rv[d], i_rv[d]}, 2'b00);
        end
      end
      if (rdy_n[0] != 0 && rdy_n[1] != 0 && rdy_n[2] != 0) break;
    end
    chk("ready_cycles", 0, rdy_n[0], 17);
    chk("ready_cycles", 1, rdy_n[1], 17);
    chk("ready_cycles", 2, rdy_n[2], 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ob, oi;
    int r;
    drive(2'b00, 5'd0, 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);
    rst_n = 1'b0;

    // Power-up sweep, then every word reads zero.
    reset_and_wait(0);
    for (int a = 0; a < 16; a++) step(2'b01, 5'(a), 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);

    // BIP write then interface read of the same word.
    step(2'b10, 5'd5, 16'h00AB, 2'b00, 5'd0, 16'h0, 1'b0);
    step(2'b00, 5'd0, 16'h0, 2'b01, 5'd5, 16'h0, 1'b0);
    step(2'b00, 5'd0, 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);

    // Read conflicts for three cycles.
    repeat (3) step(2'b01, 5'd5, 16'h0, 2'b01, 5'd1, 16'h0, 1'b0);

    // Write conflict held across two cycles, then read back.
    repeat (2) step(2'b10, 5'd2, 16'h1111, 2'b10, 5'd2, 16'h2222, 1'b0);
    step(2'b01, 5'd2, 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);
    step(2'b00, 5'd0, 16'h0, 2'b01, 5'd2, 16'h0, 1'b0);

    // Out-of-range read, illegal op, clear, set-beats-clear.
    step(2'b01, 5'd20, 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);
    step(2'b11, 5'd4, 16'h0, 2'b00, 5'd0, 16'h0, 1'b0);
    step(2'b00, 5'd0, 16'h0, 2'b00, 5'd0, 16'h0, 1'b1);
    step(2'b00, 5'd0, 16'h0, 2'b11, 5'd4, 16'h0, 1'b1);
    step(2'b10, 5'd17, 16'hBEEF, 2'b00, 5'd0, 16'h0, 1'b1);
    step(2'b00, 5'd0, 16'h0, 2'b00, 5'd0, 16'h0, 1'b1);

    // Random traffic.
    for (int k = 0; k < 200; k++) begin
      r  = $urandom_range(0, 9);
      ob = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      r  = $urandom_range(0, 9);
      oi = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      step(ob, 5'($urandom_range(0, 19)), 16'($urandom), oi, 5'($urandom_range(0, 19)),
           16'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Fill with non-zero data, reset partway through the sweep, then full sweep.
    for (int a = 0; a < 16; a++)
      step(2'b10, 5'(a), 16'(a * 16'h0111 + 1), 2'b00, 5'd0, 16'h0, 1'b0);
    reset_and_wait(7);
    reset_and_wait(0);
    for (int a = 0; a < 16; a++) step(2'b00, 5'd0, 16'h0, 2'b01, 5'(a), 16'h0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
